// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
// Purpose : free-running video timing generator with built-in test patterns
//           (solid colour, 8 colour bars, grid, checkerboard).
// Ports   :
//   pixel_clk   - pixel clock, rising edge
//   pixel_rst   - asynchronous active-high reset
//   mode        - pattern select: 0 solid, 1 bars, 2 grid, 3 checker
//                 (captured at pixel (0,0) of each frame)
//   solid_rgb   - {R,G,B} colour for mode 0, used pixel by pixel
//   vid_hs/vs   - horizontal / vertical sync, polarity set by HS_POL/VS_POL
//   vid_de      - data enable, high on active pixels
//   vid_rgb     - pixel colour {R,G,B}, zero outside the active area
//   pix_x/pix_y - active pixel coordinate, held outside the active area
//   frame_start - one-cycle pulse coincident with pixel (0,0)
//   frame_cnt   - completed-frame counter, wraps naturally
// All outputs are registered, one cycle after the counter state that
// produced them.
// ---------------------------------------------------------------------------
module video_pattern_gen #(
   parameter int HDISP    = 800,
   parameter int VDISP    = 480,
   parameter int HFP      = 40,
   parameter int HPULSE   = 48,
   parameter int HBP      = 40,
   parameter int VFP      = 13,
   parameter int VPULSE   = 3,
   parameter int VBP      = 29,
   parameter int CW       = 8,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int GRID_LOG = 4
) (
   input  logic                       pixel_clk,
   input  logic                       pixel_rst,
   input  logic [1:0]                 mode,
   input  logic [3*CW-1:0]            solid_rgb,
   output logic                       vid_hs,
   output logic                       vid_vs,
   output logic                       vid_de,
   output logic [3*CW-1:0]            vid_rgb,
   output logic [$clog2(HDISP)-1:0]   pix_x,
   output logic [$clog2(VDISP)-1:0]   pix_y,
   output logic                       frame_start,
   output logic [15:0]                frame_cnt
);

   localparam int HTOT = HDISP + HFP + HPULSE + HBP;
   localparam int VTOT = VDISP + VFP + VPULSE + VBP;
   localparam int XW   = $clog2(HDISP);
   localparam int YW   = $clog2(VDISP);
   localparam int HCW  = $clog2(HTOT);
   localparam int VCW  = $clog2(VTOT);

   localparam logic [HCW-1:0] H_ACT    = HCW'(HDISP);
   localparam logic [HCW-1:0] H_SYNC_S = HCW'(HDISP + HFP);
   localparam logic [HCW-1:0] H_SYNC_E = HCW'(HDISP + HFP + HPULSE);
   localparam logic [HCW-1:0] H_LAST   = HCW'(HTOT - 1);
   localparam logic [VCW-1:0] V_ACT    = VCW'(VDISP);
   localparam logic [VCW-1:0] V_SYNC_S = VCW'(VDISP + VFP);
   localparam logic [VCW-1:0] V_SYNC_E = VCW'(VDISP + VFP + VPULSE);
   localparam logic [VCW-1:0] V_LAST   = VCW'(VTOT - 1);

   // Reject geometries the pattern logic cannot represent.
   if (HDISP < 8 || VDISP < 2 || HFP == 0 || HPULSE == 0 || HBP == 0 ||
       VFP == 0 || VPULSE == 0 || VBP == 0) begin : g_bad_timing
      $error("video_pattern_gen: zero timing parameter or HDISP < 8");
   end
   if (GRID_LOG < 1 || GRID_LOG >= XW || GRID_LOG >= YW) begin : g_bad_grid
      $error("video_pattern_gen: GRID_LOG out of range for display size");
   end

   logic [HCW-1:0]  hcnt_q, hcnt_d;
   logic [VCW-1:0]  vcnt_q, vcnt_d;
   logic [1:0]      mode_q, mode_d;
   logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
   logic [3*CW-1:0] rgb_q, rgb_d;
   logic [XW-1:0]   pix_x_q, pix_x_d;
   logic [YW-1:0]   pix_y_q, pix_y_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;

   logic            h_last, v_last, origin, active, grid_on, checker_on;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic [7:1]      bar_ge;
   logic [2:0]      bar_idx;
   logic [2:0]      bar_mask;
   logic [3*CW-1:0] bar_rgb, pat_rgb;

   // Bar b starts at the first x with 8*x >= b*HDISP, i.e. ceil(b*HDISP/8);
   // the bar index is then just the number of boundaries already passed.
   for (genvar gi = 1; gi < 8; gi++) begin : g_bar_bound
      localparam int BND = (gi * HDISP + 7) / 8;
      assign bar_ge[gi] = int'(hcnt_q) >= BND;
   end

   always_comb begin
      bar_idx = '0;
      for (int i = 1; i < 8; i++) begin
         bar_idx = bar_idx + 3'(bar_ge[i]);
      end
   end

   always_comb begin
      h_last = (hcnt_q == H_LAST);
      v_last = (vcnt_q == V_LAST);
      origin = (hcnt_q == '0) && (vcnt_q == '0);
      active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      x      = hcnt_q[XW-1:0];
      y      = vcnt_q[YW-1:0];

      hcnt_d = hcnt_q + HCW'(1);
      vcnt_d = vcnt_q;
      if (h_last) begin
         hcnt_d = '0;
         vcnt_d = v_last ? '0 : vcnt_q + VCW'(1);
      end

      // The mode seen at pixel (0,0) is used immediately and then held.
      mode_d = origin ? mode : mode_q;

      // Colour bars as {R,G,B} on/off masks, white down to black.
      case (bar_idx)
         3'd0:    bar_mask = 3'b111;
         3'd1:    bar_mask = 3'b110;
         3'd2:    bar_mask = 3'b011;
         3'd3:    bar_mask = 3'b010;
         3'd4:    bar_mask = 3'b101;
         3'd5:    bar_mask = 3'b100;
         3'd6:    bar_mask = 3'b001;
         default: bar_mask = 3'b000;
      endcase
      bar_rgb = {{CW{bar_mask[2]}}, {CW{bar_mask[1]}}, {CW{bar_mask[0]}}};

      grid_on    = (x[GRID_LOG-1:0] == '0) || (y[GRID_LOG-1:0] == '0);
      checker_on = x[GRID_LOG] ^ y[GRID_LOG];

      case (mode_d)
         2'd0:    pat_rgb = solid_rgb;
         2'd1:    pat_rgb = bar_rgb;
         2'd2:    pat_rgb = grid_on ? '1 : '0;
         default: pat_rgb = checker_on ? '1 : '0;
      endcase

      de_d        = active;
      rgb_d       = active ? pat_rgb : '0;
      pix_x_d     = active ? x : pix_x_q;
      pix_y_d     = active ? y : pix_y_q;
      hs_d        = (hcnt_q >= H_SYNC_S && hcnt_q < H_SYNC_E) ? HS_POL : ~HS_POL;
      vs_d        = (vcnt_q >= V_SYNC_S && vcnt_q < V_SYNC_E) ? VS_POL : ~VS_POL;
      fs_d        = origin;
      frame_cnt_d = (h_last && v_last) ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         mode_q      <= '0;
         hs_q        <= ~HS_POL;
         vs_q        <= ~VS_POL;
         de_q        <= 1'b0;
         fs_q        <= 1'b0;
         rgb_q       <= '0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         frame_cnt_q <= '0;
      end else begin
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         mode_q      <= mode_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         de_q        <= de_d;
         fs_q        <= fs_d;
         rgb_q       <= rgb_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign vid_hs      = hs_q;
   assign vid_vs      = vs_q;
   assign vid_de      = de_q;
   assign vid_rgb     = rgb_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign frame_start = fs_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_gen
// Directed bench for video_pattern_gen on a small 16x8 raster (22x12 total).
// A behavioural model predicts each output cycle; the prediction is queued
// before the clock edge and popped and compared just after it.
// ---------------------------------------------------------------------------
module tb_video_pattern_gen;

   localparam int HDISP = 16, VDISP = 8, HFP = 2, HPULSE = 3, HBP = 1;
   localparam int VFP = 1, VPULSE = 2, VBP = 1, GRID_LOG = 2, CW = 8;
   localparam int HTOT = 22, VTOT = 12, FTOT = 264;

   logic           pixel_clk = 1'b0;
   logic           pixel_rst;
   logic [1:0]     mode;
   logic [23:0]    solid_rgb;
   logic           vid_hs, vid_vs, vid_de, frame_start;
   logic [23:0]    vid_rgb;
   logic [3:0]     pix_x;
   logic [2:0]     pix_y;
   logic [15:0]    frame_cnt;

   video_pattern_gen #(
      .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
      .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .CW(CW),
      .HS_POL(1'b0), .VS_POL(1'b0), .GRID_LOG(GRID_LOG)
   ) dut (
      .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode),
      .solid_rgb(solid_rgb), .vid_hs(vid_hs), .vid_vs(vid_vs),
      .vid_de(vid_de), .vid_rgb(vid_rgb), .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      logic        hs, vs, de, fs;
      logic [23:0] rgb;
      logic [3:0]  px;
      logic [2:0]  py;
      logic [15:0] fc;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          hm, vm, cur_h, cur_v;
   logic [1:0]  mode_m;
   logic [3:0]  px_m;
   logic [2:0]  py_m;
   logic [15:0] fc_m;
   int          de_cnt, hs_lo, vs_lo, fs_cnt;
   logic [23:0] cap [8][16];
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at h=%0d v=%0d observed=%h expected=%h", tag, cur_h, cur_v, obs, exp);
      end
   endtask

   task automatic model_reset();
      hm = 0; vm = 0; mode_m = 2'd0; px_m = '0; py_m = '0; fc_m = '0;
      sb.delete();
   endtask

   task automatic clear_tallies();
      de_cnt = 0; hs_lo = 0; vs_lo = 0; fs_cnt = 0;
   endtask

   task automatic check_reset_values(input string when);
      cur_h = -1; cur_v = -1;
      check({when, "_hs"},  32'(vid_hs), 32'd1);
      check({when, "_vs"},  32'(vid_vs), 32'd1);
      check({when, "_de"},  32'(vid_de), 32'd0);
      check({when, "_rgb"}, 32'(vid_rgb), 32'd0);
      check({when, "_fs"},  32'(frame_start), 32'd0);
      check({when, "_fc"},  32'(frame_cnt), 32'd0);
      check({when, "_px"},  32'(pix_x), 32'd0);
      check({when, "_py"},  32'(pix_y), 32'd0);
   endtask

   // One pixel clock: predict, clock, compare, advance the model raster.
   task automatic step();
      exp_t       e, g;
      logic       act;
      logic [1:0] em;
      act    = (hm < HDISP) && (vm < VDISP);
      em     = (hm == 0 && vm == 0) ? mode : mode_m;
      mode_m = em;
      e.de   = act;
      if (!act)          e.rgb = 24'h0;
      else if (em == 0)  e.rgb = solid_rgb;
      else if (em == 1)  e.rgb = bars[(8 * hm) / HDISP];
      else if (em == 2)  e.rgb = (hm % 4 == 0 || vm % 4 == 0) ? 24'hFFFFFF : 24'h0;
      else               e.rgb = (((hm / 4) ^ (vm / 4)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
      if (act) begin
         px_m = 4'(hm);
         py_m = 3'(vm);
      end
      e.px = px_m;
      e.py = py_m;
      e.hs = !(hm >= 18 && hm < 21);
      e.vs = !(vm >= 9 && vm < 11);
      e.fs = (hm == 0 && vm == 0);
      if (hm == HTOT - 1 && vm == VTOT - 1) fc_m = fc_m + 16'd1;
      e.fc = fc_m;
      sb.push_back(e);

      @(posedge pixel_clk);
      #1;
      cur_h = hm; cur_v = vm;
      g = sb.pop_front();
      check("de",  32'(vid_de), 32'(g.de));
      check("rgb", 32'(vid_rgb), 32'(g.rgb));
      check("px",  32'(pix_x), 32'(g.px));
      check("py",  32'(pix_y), 32'(g.py));
      check("hs",  32'(vid_hs), 32'(g.hs));
      check("vs",  32'(vid_vs), 32'(g.vs));
      check("fs",  32'(frame_start), 32'(g.fs));
      check("fc",  32'(frame_cnt), 32'(g.fc));
      if (vid_de) begin
         de_cnt++;
         if (hm < HDISP && vm < VDISP) cap[vm][hm] = vid_rgb;
      end
      if (!vid_hs) hs_lo++;
      if (!vid_vs) vs_lo++;
      if (frame_start) fs_cnt++;

      hm++;
      if (hm == HTOT) begin
         hm = 0;
         vm = (vm == VTOT - 1) ? 0 : vm + 1;
      end
   endtask

   initial begin
      pixel_rst = 1'b1;
      mode      = 2'd0;
      solid_rgb = 24'h123456;
      repeat (3) @(posedge pixel_clk);
      #1;
      check_reset_values("in_reset");
      $display("[TB] reset held: outputs checked");

      pixel_rst = 1'b0;
      model_reset();
      clear_tallies();
      repeat (FTOT) step();
      cur_h = -1; cur_v = -1;
      check("frame1_de_cycles", 32'(de_cnt), 32'd128);
      check("frame1_hs_low",    32'(hs_lo),  32'd36);
      check("frame1_vs_low",    32'(vs_lo),  32'd44);
      check("frame1_fs_pulses", 32'(fs_cnt), 32'd1);
      check("frame1_fc",        32'(frame_cnt), 32'd1);
      $display("[TB] frame 1 solid 0x123456 done");

      clear_tallies();
      for (int i = 0; i < FTOT; i++) begin
         if (i == 100) mode = 2'd3;
         solid_rgb = 24'($urandom);
         step();
      end
      cur_h = -1; cur_v = -1;
      check("frame2_fs_pulses", 32'(fs_cnt), 32'd1);
      $display("[TB] frame 2 per-pixel solid, mode->3 at cycle 100 done");

      repeat (FTOT) step();
      cur_h = -1; cur_v = -1;
      check("checker_0_0", 32'(cap[0][0]), 32'h000000);
      check("checker_4_0", 32'(cap[0][4]), 32'hFFFFFF);
      check("checker_4_4", 32'(cap[4][4]), 32'h000000);
      $display("[TB] frame 3 checker done");

      mode = 2'd1;
      repeat (FTOT) step();
      cur_h = -1; cur_v = -1;
      for (int r = 0; r < VDISP; r++) begin
         check("bars_x0",  32'(cap[r][0]),  32'hFFFFFF);
         check("bars_x1",  32'(cap[r][1]),  32'hFFFFFF);
         check("bars_x14", 32'(cap[r][14]), 32'h000000);
         check("bars_x15", 32'(cap[r][15]), 32'h000000);
      end
      $display("[TB] frame 4 colour bars done");

      mode = 2'd2;
      repeat (FTOT) step();
      cur_h = -1; cur_v = -1;
      check("grid_0_1", 32'(cap[1][0]), 32'hFFFFFF);
      check("grid_1_1", 32'(cap[1][1]), 32'h000000);
      check("grid_4_4", 32'(cap[4][4]), 32'hFFFFFF);
      check("grid_5_5", 32'(cap[5][5]), 32'h000000);
      $display("[TB] frame 5 grid done");

      mode      = 2'd0;
      solid_rgb = 24'hA5C3E1;
      repeat (150) step();
      pixel_rst = 1'b1;
      #1;
      check_reset_values("async_reset");
      model_reset();
      @(posedge pixel_clk);
      #1;
      check_reset_values("reset_held");
      pixel_rst = 1'b0;
      $display("[TB] mid-frame reset at cycle 150 done");

      clear_tallies();
      repeat (FTOT) step();
      cur_h = -1; cur_v = -1;
      check("restart_fs_pulses", 32'(fs_cnt), 32'd1);
      check("restart_de_cycles", 32'(de_cnt), 32'd128);
      check("restart_fc",        32'(frame_cnt), 32'd1);
      $display("[TB] frame after reset release done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameter HDISP, default 800: active pixels per line.
REQ-002 Parameter VDISP, default 480: active lines per frame.
REQ-003 Parameters HFP/HPULSE/HBP, defaults 40/48/40: horizontal front porch, sync width and back porch, in pixels.
REQ-004 Parameters VFP/VPULSE/VBP, defaults 13/3/29: vertical front porch, sync width and back porch, in lines.
REQ-005 Parameter CW, default 8: bits per colour channel.
REQ-006 Parameters HS_POL/VS_POL, default 0: asserted level of vid_hs/vid_vs (0 = active low).
REQ-007 Parameter GRID_LOG, default 4: grid and checker cell size is 2^GRID_LOG pixels.
REQ-008 pixel_clk  in  1: pixel clock; all logic is on the rising edge.
REQ-009 pixel_rst  in  1: reset, asynchronous, active-high.
REQ-010 mode  in  2: pattern select (0 solid, 1 colour bars, 2 grid, 3 checker).
REQ-011 solid_rgb  in  3*CW: colour used in mode 0, packed {R,G,B}.
REQ-012 vid_hs  out  1: horizontal sync.
REQ-013 vid_vs  out  1: vertical sync.
REQ-014 vid_de  out  1: data enable, high during active pixels.
REQ-015 vid_rgb  out  3*CW: pixel colour {R,G,B}.
REQ-016 pix_x  out  clog2(HDISP): active pixel column, valid when vid_de=1.
REQ-017 pix_y  out  clog2(VDISP): active line, valid when vid_de=1.
REQ-018 frame_start  out  1: one-cycle pulse, aligned with pixel (0,0).
REQ-019 frame_cnt  out  16: completed-frame counter; wraps 0xFFFF->0.

Function
REQ-020 Define HTOT = HDISP+HFP+HPULSE+HBP and VTOT = VDISP+VFP+VPULSE+VBP.
REQ-021 hcnt SHALL count 0..HTOT-1 and wrap to 0; vcnt SHALL increment when hcnt wraps and SHALL itself wrap VTOT-1->0.
REQ-022 Line order: active [0,HDISP), front porch, sync [HDISP+HFP, HDISP+HFP+HPULSE), back porch; vertical order identical, using vcnt.
REQ-023 Every output SHALL be registered, 1-cycle latency from the (hcnt,vcnt) that produced it.
REQ-024 vid_de = (hcnt<HDISP) and (vcnt<VDISP).
REQ-025 Outside active: vid_rgb=0, and pix_x/pix_y hold their last values.
REQ-026 vid_hs = HS_POL inside the horizontal sync window, else ~HS_POL; vid_vs likewise, using vcnt and VS_POL, over whole lines.
REQ-027 mode SHALL be sampled only when hcnt=0 and vcnt=0; a change mid-frame takes effect from the next frame's pixel (0,0).
REQ-028 solid_rgb SHALL be sampled every pixel (not frame-latched).
REQ-029 Mode 0: vid_rgb = solid_rgb.
REQ-030 Mode 1: bar index b = floor(8*x/HDISP), 0..7.
REQ-031 Mode 1 bar colours, b=0..7: white, yellow, cyan, green, magenta, red, blue, black; a full channel is all ones.
REQ-032 Mode 1 bar boundaries SHALL come from constants precomputed at elaboration (no runtime divider).
REQ-033 Mode 2: white when x[GRID_LOG-1:0]=0 or y[GRID_LOG-1:0]=0, else black.
REQ-034 Mode 3: white when x[GRID_LOG]^y[GRID_LOG]=1, else black.
REQ-035 frame_start SHALL pulse high for exactly one cycle, coincident with vid_de for pixel (0,0).
REQ-036 frame_cnt SHALL increment when hcnt=HTOT-1 and vcnt=VTOT-1.
REQ-037 Elaboration error if any timing parameter is 0, or if HDISP < 8 (mode 1 needs 8 bars).

Reset
REQ-038 While pixel_rst=1: hcnt=vcnt=0, stored mode=0, vid_de=0, vid_rgb=0, frame_start=0, frame_cnt=0, pix_x=pix_y=0, vid_hs=~HS_POL, vid_vs=~VS_POL.
REQ-039 On the first edge after release, counters SHALL advance from (0,0), and outputs for pixel (0,0) SHALL appear there with frame_start=1 and mode sampled at that moment.
REQ-040 Reset asserted mid-frame SHALL force the REQ-038 values immediately (asynchronously); there is no partial-frame recovery.

Verification (HDISP=16, VDISP=8, HFP=2, HPULSE=3, HBP=1, VFP=1, VPULSE=2, VBP=1, GRID_LOG=2, CW=8)
REQ-041 Release reset, mode=0, solid_rgb=0x123456 -> frame_start at the first post-reset edge.
REQ-042 Same run -> vid_rgb=0x123456 for exactly 16 cycles per line, with vid_de high for those 16 cycles.
REQ-043 Same run -> vid_hs low for 3 cycles starting at line offset 18, with line period 22 cycles.
REQ-044 Timing -> vid_vs low for 2 lines (44 cycles) starting at line 9; frame period 264 cycles; frame_cnt=1 after 264 cycles.
REQ-045 mode=1 -> in each active line, each of the 8 colours spans 2 pixels (x=0,1 white 0xFFFFFF; x=14,15 black 0x000000).
REQ-046 mode=2 -> pixel (0,1) white, (1,1) black, (4,4) white, (5,5) black.
REQ-047 mode=3 -> pixel (0,0) black, (4,0) white, (4,4) black.
REQ-048 mode changed 0->3 at cycle 100 -> no change before the next frame_start, then the checker pattern appears.
REQ-049 Reset pulsed at cycle 150 -> outputs at the REQ-038 values within the cycle; frame_cnt=0; clean frame restarts after release.
